// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment sequence path: segment codes,
// the display ring and the tracker state encoding.
package seg_pkg;

  // Active-low segment codes, bit6..0 = g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit value reported for any code that is not a decimal digit
  localparam logic [3:0] DIGIT_NONE = 4'hF;

  // Fixed display ring driven by the sequencer
  localparam int RING_LEN = 5;
  localparam logic [3:0] RING [0:RING_LEN-1] = '{4'd2, 4'd3, 4'd6, 4'd5, 4'd7};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  // Forward successor of a ring index (wraps 4 -> 0)
  function automatic logic [2:0] ring_next(input logic [2:0] idx);
    return (idx == 3'(RING_LEN - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  // Backward predecessor of a ring index (wraps 0 -> 4)
  function automatic logic [2:0] ring_prev(input logic [2:0] idx);
    return (idx == 3'd0) ? 3'(RING_LEN - 1) : idx - 3'd1;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational active-low 7-segment to BCD decoder. Any code that is not
// one of the ten digit patterns (including X/Z bits) reports DIGIT_NONE
// with valid low.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       valid
);

  // Map segment pattern to digit; unmatched patterns fall to DIGIT_NONE
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    digit = DIGIT_NONE;
    case (seg_in)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: digit = DIGIT_NONE;
    endcase
    valid = (digit != DIGIT_NONE);
  end

endmodule

// File: rtl/seg_sequence_decoder.sv
// Receive-side checker for the 7-segment digit sequencer. Decodes each
// sampled code, locks onto the 2-3-6-5-7 ring and reports position,
// step direction, a saturating step count and sequence errors.
// All outputs are registered; latency from sample_en is one cycle.
module seg_sequence_decoder
  import seg_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [6:0]       seg_in,
  input  logic             clr_err,
  output logic [3:0]       digit,
  output logic             bad_code,
  output logic [2:0]       pos,
  output logic             dir,
  output logic             step_fwd,
  output logic             step_back,
  output logic [CNT_W-1:0] step_cnt,
  output logic             seq_err,
  output logic             locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_digit, w_digit_nxt;
  logic             r_bad_code, w_bad_code_nxt;
  logic [2:0]       r_pos, w_pos_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_step_fwd, w_step_fwd_nxt;
  logic             r_step_back, w_step_back_nxt;
  logic [CNT_W-1:0] r_step_cnt, w_step_cnt_nxt;

  logic [3:0]       w_dec_digit;
  logic             w_dec_valid;
  logic             w_in_ring;
  logic [2:0]       w_ring_idx;
  logic             w_take;

  seg7_to_bcd u_dec (
    .seg_in (seg_in),
    .digit  (w_dec_digit),
    .valid  (w_dec_valid)
  );

  // Locate the decoded digit in the ring table
  always_comb begin
    w_in_ring  = 1'b0;
    w_ring_idx = 3'd0;
    for (int i = 0; i < RING_LEN; i++) begin
      if (w_dec_valid && (RING[i] == w_dec_digit)) begin
        w_in_ring  = 1'b1;
        w_ring_idx = 3'(i);
      end
    end
  end

  // A clear in ERR takes priority and drops the sample entirely
  assign w_take = sample_en && !((r_state == ERR) && clr_err);

  // Next-state and next-output logic; pulses default low, state holds
  always_comb begin
    w_state_nxt     = r_state;
    w_digit_nxt     = r_digit;
    w_bad_code_nxt  = 1'b0;
    w_pos_nxt       = r_pos;
    w_dir_nxt       = r_dir;
    w_step_fwd_nxt  = 1'b0;
    w_step_back_nxt = 1'b0;
    w_step_cnt_nxt  = r_step_cnt;

    if (w_take) begin
      w_digit_nxt    = w_dec_digit;
      w_bad_code_nxt = !w_dec_valid;
    end

    case (r_state)
      IDLE: begin
        if (w_take && w_in_ring) begin
          w_pos_nxt   = w_ring_idx;
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (w_take) begin
          if (w_in_ring && (w_ring_idx == r_pos)) begin
            // Repeated digit: hold position, no step
          end else if (w_in_ring && (w_ring_idx == ring_next(r_pos))) begin
            w_step_fwd_nxt = 1'b1;
            w_dir_nxt      = 1'b1;
            w_pos_nxt      = w_ring_idx;
            if (r_step_cnt != CNT_MAX) w_step_cnt_nxt = r_step_cnt + CNT_ONE;
          end else if (w_in_ring && (w_ring_idx == ring_prev(r_pos))) begin
            w_step_back_nxt = 1'b1;
            w_dir_nxt       = 1'b0;
            w_pos_nxt       = w_ring_idx;
            if (r_step_cnt != CNT_MAX) w_step_cnt_nxt = r_step_cnt + CNT_ONE;
          end else begin
            w_state_nxt = ERR;
          end
        end
      end
      ERR: begin
        if (clr_err) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_state     <= IDLE;
      r_digit     <= DIGIT_NONE;
      r_bad_code  <= 1'b0;
      r_pos       <= 3'd0;
      r_dir       <= 1'b1;
      r_step_fwd  <= 1'b0;
      r_step_back <= 1'b0;
      r_step_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_digit     <= w_digit_nxt;
      r_bad_code  <= w_bad_code_nxt;
      r_pos       <= w_pos_nxt;
      r_dir       <= w_dir_nxt;
      r_step_fwd  <= w_step_fwd_nxt;
      r_step_back <= w_step_back_nxt;
      r_step_cnt  <= w_step_cnt_nxt;
    end
  end

  assign digit     = r_digit;
  assign bad_code  = r_bad_code;
  assign pos       = r_pos;
  assign dir       = r_dir;
  assign step_fwd  = r_step_fwd;
  assign step_back = r_step_back;
  assign step_cnt  = r_step_cnt;
  assign locked    = (r_state == TRACK);
  assign seq_err   = (r_state == ERR);

endmodule

// File: tb/tb_seg_sequence_decoder.sv
// Bench for seg_sequence_decoder: two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream. A behavioural model predicts every output,
// a compare process checks it each cycle, and directed literal checks
// pin the model at key points.
module tb_seg_sequence_decoder;

  logic       clk;
  logic       reset;
  logic       sample_en;
  logic [6:0] seg_in;
  logic       clr_err;

  logic [3:0] a_digit;
  logic       a_bad_code;
  logic [2:0] a_pos;
  logic       a_dir;
  logic       a_step_fwd;
  logic       a_step_back;
  logic [7:0] a_step_cnt;
  logic       a_seq_err;
  logic       a_locked;

  logic [3:0] b_digit;
  logic       b_bad_code;
  logic [2:0] b_pos;
  logic       b_dir;
  logic       b_step_fwd;
  logic       b_step_back;
  logic [1:0] b_step_cnt;
  logic       b_seq_err;
  logic       b_locked;

  int n_tests = 0;
  int n_fail  = 0;

  seg_sequence_decoder #(.CNT_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .seg_in    (seg_in),
    .clr_err   (clr_err),
    .digit     (a_digit),
    .bad_code  (a_bad_code),
    .pos       (a_pos),
    .dir       (a_dir),
    .step_fwd  (a_step_fwd),
    .step_back (a_step_back),
    .step_cnt  (a_step_cnt),
    .seq_err   (a_seq_err),
    .locked    (a_locked)
  );

  seg_sequence_decoder #(.CNT_W(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .seg_in    (seg_in),
    .clr_err   (clr_err),
    .digit     (b_digit),
    .bad_code  (b_bad_code),
    .pos       (b_pos),
    .dir       (b_dir),
    .step_fwd  (b_step_fwd),
    .step_back (b_step_back),
    .step_cnt  (b_step_cnt),
    .seq_err   (b_seq_err),
    .locked    (b_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tables written straight from the decode table and ring order
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  int ring_tab [5] = '{2, 3, 6, 5, 7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_decode(input logic [6:0] code);
    for (int i = 0; i < 10; i++) if (code === seg_tab[i]) return i;
    return 15;
  endfunction

  function automatic int model_ring(input int d);
    for (int i = 0; i < 5; i++) if (ring_tab[i] == d) return i;
    return -1;
  endfunction

  // Behavioural model: 0 = waiting for a ring digit, 1 = tracking, 2 = error
  bit m_valid = 1'b0;
  int m_mode, m_digit, m_pos, m_cnt8, m_cnt2;
  bit m_dir, m_bad, m_fwd, m_back;

  always @(posedge clk) begin
    int d, r;
    m_bad  = 1'b0;
    m_fwd  = 1'b0;
    m_back = 1'b0;
    if (reset) begin
      m_valid = 1'b1;
      m_mode  = 0;
      m_digit = 15;
      m_pos   = 0;
      m_dir   = 1'b1;
      m_cnt8  = 0;
      m_cnt2  = 0;
    end else if (m_mode == 2 && clr_err) begin
      m_mode = 0;
    end else if (sample_en) begin
      d       = model_decode(seg_in);
      r       = model_ring(d);
      m_digit = d;
      m_bad   = (d == 15);
      if (m_mode == 0) begin
        if (r >= 0) begin
          m_pos  = r;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (r < 0) begin
          m_mode = 2;
        end else if (r == m_pos) begin
          // hold
        end else if (r == (m_pos + 1) % 5 || r == (m_pos + 4) % 5) begin
          m_fwd  = (r == (m_pos + 1) % 5);
          m_back = !m_fwd;
          m_dir  = m_fwd;
          m_pos  = r;
          m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end else begin
          m_mode = 2;
        end
      end
    end
  end

  // Compare both DUTs against the model every cycle once reset has been seen
  always @(negedge clk) begin
    if (m_valid) begin
      check("digit",      32'(a_digit),     32'(m_digit));
      check("bad_code",   32'(a_bad_code),  32'(m_bad));
      check("pos",        32'(a_pos),       32'(m_pos));
      check("dir",        32'(a_dir),       32'(m_dir));
      check("step_fwd",   32'(a_step_fwd),  32'(m_fwd));
      check("step_back",  32'(a_step_back), 32'(m_back));
      check("step_cnt",   32'(a_step_cnt),  32'(m_cnt8));
      check("locked",     32'(a_locked),    32'(m_mode == 1));
      check("seq_err",    32'(a_seq_err),   32'(m_mode == 2));
      check("b_pos",      32'(b_pos),       32'(m_pos));
      check("b_step_fwd", 32'(b_step_fwd),  32'(m_fwd));
      check("b_step_cnt", 32'(b_step_cnt),  32'(m_cnt2));
      check("b_locked",   32'(b_locked),    32'(m_mode == 1));
    end
  end

  // Drive one cycle of inputs on the falling edge, return just after the rising edge
  task automatic cyc(input logic en, input logic [6:0] code, input logic clr, input logic rst);
    @(negedge clk);
    sample_en = en;
    seg_in    = code;
    clr_err   = clr;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_digit"},  32'(a_digit),    32'hF);
    check({tag, "_pos"},    32'(a_pos),      32'd0);
    check({tag, "_dir"},    32'(a_dir),      32'd1);
    check({tag, "_cnt"},    32'(a_step_cnt), 32'd0);
    check({tag, "_locked"}, 32'(a_locked),   32'd0);
    check({tag, "_seqerr"}, 32'(a_seq_err),  32'd0);
    check({tag, "_b_cnt"},  32'(b_step_cnt), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    sample_en = 1'b0;
    seg_in    = 7'b1111111;
    clr_err   = 1'b0;

    cyc(1'b0, 7'b1111111, 1'b0, 1'b1);
    cyc(1'b0, 7'b1111111, 1'b0, 1'b1);
    check_reset_state("rst");

    // Lock on digit 2
    cyc(1'b1, 7'b0100100, 1'b0, 1'b0);
    check("lock_digit",  32'(a_digit),    32'd2);
    check("lock_pos",    32'(a_pos),      32'd0);
    check("lock_locked", 32'(a_locked),   32'd1);
    check("lock_cnt",    32'(a_step_cnt), 32'd0);
    check("lock_fwd",    32'(a_step_fwd), 32'd0);
    cyc(1'b0, 7'b1111111, 1'b0, 1'b0);

    // Five forward steps 3,6,5,7,2 with wrap back to index 0
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, seg_tab[ring_tab[(k + 1) % 5]], 1'b0, 1'b0);
      check("fwd_pulse", 32'(a_step_fwd), 32'd1);
      check("fwd_pos",   32'(a_pos),      32'((k + 1) % 5));
    end
    check("fwd_dir",   32'(a_dir),      32'd1);
    check("fwd_cnt",   32'(a_step_cnt), 32'd5);
    check("fwd_b_cnt", 32'(b_step_cnt), 32'd3);

    // Backward step 2 -> 7, then a repeat holds
    cyc(1'b1, 7'b1111000, 1'b0, 1'b0);
    check("back_pulse", 32'(a_step_back), 32'd1);
    check("back_pos",   32'(a_pos),       32'd4);
    check("back_dir",   32'(a_dir),       32'd0);
    cyc(1'b1, 7'b1111000, 1'b0, 1'b0);
    check("rep_back",   32'(a_step_back), 32'd0);
    check("rep_cnt",    32'(a_step_cnt),  32'd6);

    // Return to index 0, then jump to 6 -> error
    cyc(1'b1, 7'b0100100, 1'b0, 1'b0);
    cyc(1'b1, 7'b0000010, 1'b0, 1'b0);
    check("jump_seqerr", 32'(a_seq_err), 32'd1);
    check("jump_locked", 32'(a_locked),  32'd0);
    check("jump_pos",    32'(a_pos),     32'd0);
    cyc(1'b0, 7'b0100100, 1'b0, 1'b0);
    cyc(1'b1, 7'b1111111, 1'b0, 1'b0);
    check("err_bad",   32'(a_bad_code), 32'd1);
    check("err_digit", 32'(a_digit),    32'hF);
    cyc(1'b1, 7'b0000000, 1'b1, 1'b0);
    check("clr_seqerr", 32'(a_seq_err),  32'd0);
    check("clr_drop",   32'(a_digit),    32'hF);
    check("clr_cnt",    32'(a_step_cnt), 32'd7);

    // IDLE: blank code, non-ring digit, stray clr_err
    cyc(1'b1, 7'b1111111, 1'b0, 1'b0);
    check("idle_bad",    32'(a_bad_code), 32'd1);
    cyc(1'b1, 7'b0011001, 1'b0, 1'b0);
    check("idle_digit4", 32'(a_digit),    32'd4);
    check("idle_locked", 32'(a_locked),   32'd0);
    cyc(1'b0, 7'b0011001, 1'b1, 1'b0);

    // Relock on 5, then an unrecognised code in TRACK
    cyc(1'b1, 7'b0010010, 1'b0, 1'b0);
    check("relock_pos", 32'(a_pos), 32'd3);
    cyc(1'b1, 7'b0101010, 1'b0, 1'b0);
    check("trk_bad",    32'(a_bad_code), 32'd1);
    check("trk_seqerr", 32'(a_seq_err),  32'd1);
    cyc(1'b0, 7'b0101010, 1'b1, 1'b0);

    // Long forward run saturates the 8-bit counter
    cyc(1'b1, 7'b0100100, 1'b0, 1'b0);
    for (int k = 0; k < 260; k++) cyc(1'b1, seg_tab[ring_tab[(k + 1) % 5]], 1'b0, 1'b0);
    check("sat_cnt8",  32'(a_step_cnt), 32'd255);
    check("sat_cnt2",  32'(b_step_cnt), 32'd3);
    check("sat_pulse", 32'(a_step_fwd), 32'd1);

    // Reset while tracking, with a sample offered at the same time
    cyc(1'b1, seg_tab[ring_tab[1]], 1'b0, 1'b1);
    check_reset_state("rst2");

    cyc(1'b0, 7'b1111111, 1'b0, 1'b0);
    cyc(1'b0, 7'b1111111, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
